// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Posted-write store buffer sitting between the MEM stage and a data memory
//   that is clocked on the falling edge. Stores are queued in a DEPTH-entry
//   FIFO and retired to memory in any cycle that does not need the port for a
//   load miss. Loads that hit a queued store are forwarded from the youngest
//   matching entry; misses read memory in the same cycle.
//
//   Optional feature macro: STORE_BUF_BYPASS_EN
//     When defined, a store that finds the buffer empty (and no load miss
//     competing for the port) is written straight to memory and not queued.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   cpu_we     MEM-stage store request
//   cpu_re     MEM-stage load request
//   cpu_addr   byte address (addr[1:0] ignored for matching)
//   cpu_wdata  store data
//   cpu_rdata  load data back to the pipeline (combinational)
//   stall      store could not be accepted this cycle
//   mem_en     data-memory enable
//   mem_we     data-memory write strobe (all byte lanes)
//   mem_addr   data-memory address
//   mem_wdata  data-memory write data
//   mem_rdata  data-memory read data, valid in the same cycle
//   sb_empty   no stores queued
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    entryAddr [DEPTH];
  logic [DW-1:0]    entryData [DEPTH];
  logic [DEPTH-1:0] entryValid;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          hit;
  logic [DW-1:0] hitData;
  logic          loadMiss;
  logic          drain;
  logic          bypass;
  logic          full;
  logic          push;
  logic          pop;

  // Forwarding search: walk from oldest (head) to youngest so the last match
  // seen wins. Valid entries are always contiguous starting at head.
  always_comb begin
    logic [PW-1:0] idx;
    hit     = 1'b0;
    hitData = '0;
    idx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (entryValid[idx] && (entryAddr[idx][AW-1:2] == cpu_addr[AW-1:2])) begin
        hit     = 1'b1;
        hitData = entryData[idx];
      end
    end
  end

  assign loadMiss = cpu_re & ~hit;
  assign drain    = (count != '0) & ~loadMiss;
  assign full     = (count == CW'(DEPTH));
  assign sb_empty = (count == '0);

`ifdef STORE_BUF_BYPASS_EN
  // An empty buffer holds nothing older, so writing through keeps ordering.
  assign bypass = cpu_we & (count == '0) & ~loadMiss;
`else
  assign bypass = 1'b0;
`endif

  // A drain frees the head slot in the same edge, so a full buffer can still
  // accept a store while draining.
  assign stall = cpu_we & full & ~drain;
  assign push  = cpu_we & ~stall & ~bypass;
  assign pop   = drain;

  assign cpu_rdata = hit ? hitData : mem_rdata;

  // Memory port arbitration: load miss, then drain, then bypass write.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = entryAddr[head];
    mem_wdata = entryData[head];
    if (loadMiss) begin
      mem_en   = 1'b1;
      mem_addr = cpu_addr;
    end else if (drain) begin
      mem_en = 1'b1;
      mem_we = 1'b1;
    end else if (bypass) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Control state: pointers, occupancy and valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      // Pop clears before push sets, so a push into the slot being popped
      // (push and pop at full) leaves the slot valid.
      if (pop) begin
        entryValid[head] <= 1'b0;
        head             <= head + 1'b1;
      end
      if (push) begin
        entryValid[tail] <= 1'b1;
        tail             <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      entryAddr[tail] <= cpu_addr;
      entryData[tail] <= cpu_wdata;
    end
  end

endmodule
